// File: rtl/ram_dual_stream_reader_if.sv
// ram_dual_stream_reader_if: command, RAM read-port and output-stream signals of the dual-port RAM reader.
interface ram_dual_stream_reader_if #(parameter int AW = 6, parameter int DW = 16);
   logic          cmd_valid;
   logic          cmd_ready;
   logic [AW-1:0] cmd_addr;
   logic [AW:0]   cmd_len;
   logic          ram_en;
   logic [AW-1:0] ram_addra;
   logic [AW-1:0] ram_addrb;
   logic [DW-1:0] ram_doa;
   logic [DW-1:0] ram_dob;
   logic          m_valid;
   logic          m_ready;
   logic [2*DW-1:0] m_data;
   logic [1:0]    m_keep;
   logic          m_last;
   logic          busy;
   modport master (
      input  cmd_valid, cmd_addr, cmd_len, ram_doa, ram_dob, m_ready,
      output cmd_ready, ram_en, ram_addra, ram_addrb, m_valid, m_data, m_keep, m_last, busy
   );
   modport slave (
      output cmd_valid, cmd_addr, cmd_len, ram_doa, ram_dob, m_ready,
      input  cmd_ready, ram_en, ram_addra, ram_addrb, m_valid, m_data, m_keep, m_last, busy
   );
endinterface

// File: rtl/ram_dual_stream_reader.sv
// ram_dual_stream_reader: streams (addr,len) commands from a dual-port RAM as two-word beats.
// Define RAM_READER_BEAT_CNT_EN to add the saturating beat_count output.
module ram_dual_stream_reader #(
   parameter int AW = 6,
   parameter int DW = 16
) (
   input  logic clk,
   input  logic rst,
   ram_dual_stream_reader_if.master bus
`ifdef RAM_READER_BEAT_CNT_EN
   , output logic [15:0] beat_count
`endif
);
   typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
   state_t state, state_n;
   logic [AW-1:0] ptr;
   logic [AW:0]   rem;
   logic          m_valid, m_last;
   logic [1:0]    m_keep;
   logic          accept, issue, hs;
   assign bus.cmd_ready = (state == IDLE) && !rst;
   assign accept        = bus.cmd_valid && bus.cmd_ready;
   assign hs            = m_valid && bus.m_ready;
   // Holding ram_en low under backpressure freezes the RAM read registers, keeping m_data stable.
   assign issue         = (state == STREAM) && !rst && (!m_valid || bus.m_ready);
   assign bus.ram_en    = issue;
   assign bus.ram_addra = rst ? '0 : ptr;
   assign bus.ram_addrb = rst ? '0 : ptr + AW'(1);
   assign bus.m_valid   = m_valid;
   assign bus.m_data    = {bus.ram_dob, bus.ram_doa};
   assign bus.m_keep    = m_keep;
   assign bus.m_last    = m_last;
   assign bus.busy      = state != IDLE;
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    state_n = (accept && bus.cmd_len != '0) ? STREAM : IDLE;
         STREAM:  state_n = (issue && rem <= (AW+1)'(2)) ? DRAIN : STREAM;
         DRAIN:   state_n = (hs && m_last) ? IDLE : DRAIN;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ptr     <= '0;
         rem     <= '0;
         m_valid <= 1'b0;
         m_keep  <= 2'b00;
         m_last  <= 1'b0;
      end else begin
         state <= state_n;
         if (accept) begin
            ptr <= bus.cmd_addr;
            rem <= bus.cmd_len;
         end
         if (issue) begin
            ptr     <= ptr + AW'(2);
            rem     <= (rem > (AW+1)'(2)) ? rem - (AW+1)'(2) : '0;
            m_valid <= 1'b1;
            m_keep  <= (rem == (AW+1)'(1)) ? 2'b01 : 2'b11;
            m_last  <= rem <= (AW+1)'(2);
         end else if (hs) begin
            m_valid <= 1'b0;
         end
      end
   end
`ifdef RAM_READER_BEAT_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) beat_count <= '0;
      else if (hs && beat_count != 16'hFFFF) beat_count <= beat_count + 16'd1;
   end
`endif
endmodule
